// File: rtl/data_mem_responder.sv
// 256 x 8-bit data memory with a fixed multi-cycle access latency.
// Serves one CPU load or store at a time and stalls the CPU with BUSYWAIT until the access completes.
module data_mem_responder #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 256
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READ,
    input  logic       WRITE,
    input  logic [7:0] ADDRESS,
    input  logic [7:0] WRITEDATA,
    output logic [7:0] READDATA,
    output logic       BUSYWAIT,
    output logic       ERR
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

    state_t     state;
    logic [3:0] count;
    logic       is_write_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] mem [DEPTH];

    logic req_one;
    logic req_both;
    logic access_now;

    assign req_one    = READ ^ WRITE;
    assign req_both   = READ & WRITE;
    assign access_now = (state == BUSY) && (count == 4'd0);

    // The stall must rise in the request cycle itself, so it is decoded from the live inputs.
    assign BUSYWAIT = RESET & (((state == IDLE) & req_one) | (state == BUSY));

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            count      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            READDATA   <= 8'h00;
            ERR        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            ERR <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_one) begin
                        state      <= BUSY;
                        count      <= COUNT_INIT;
                        is_write_q <= WRITE;
                        addr_q     <= ADDRESS;
                        wdata_q    <= WRITEDATA;
                    end else if (req_both) begin
                        ERR <= 1'b1;
                    end
                end
                BUSY: begin
                    if (count == 4'd0) begin
                        if (!is_write_q) begin
                            READDATA <= mem[addr_q];
                        end
                        state <= DONE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // NOTE: contents must read as zero after reset, so the array is built from resettable
    // flops rather than a RAM macro, which cannot be cleared asynchronously.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (access_now && is_write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a timestamp-based transaction model checked every cycle,
// plus directed scenarios with literal expectations and a LATENCY=1 instance.
module tb_data_mem_responder;

    localparam int LAT = 5;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       READ = 1'b0;
    logic       WRITE = 1'b0;
    logic [7:0] ADDRESS = 8'h00;
    logic [7:0] WRITEDATA = 8'h00;
    logic [7:0] READDATA;
    logic       BUSYWAIT;
    logic       ERR;

    logic       read2 = 1'b0;
    logic       write2 = 1'b0;
    logic [7:0] addr2 = 8'h00;
    logic [7:0] wdata2 = 8'h00;
    logic [7:0] rdata2;
    logic       busy2;
    logic       err2;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_responder #(.LATENCY(LAT), .DEPTH(256)) dut (
        .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA),
        .READDATA(READDATA), .BUSYWAIT(BUSYWAIT), .ERR(ERR)
    );

    data_mem_responder #(.LATENCY(1), .DEPTH(256)) dut_lat1 (
        .CLK(CLK), .RESET(RESET), .READ(read2), .WRITE(write2),
        .ADDRESS(addr2), .WRITEDATA(wdata2),
        .READDATA(rdata2), .BUSYWAIT(busy2), .ERR(err2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: an accepted request completes LATENCY edges later; the edge after
    // completion is the single DONE cycle in which new requests are ignored.
    int         edge_n;
    int         done_at;
    int         acc_edge;
    bit         pending;
    bit         m_idle;
    logic       m_is_wr;
    logic [7:0] m_a;
    logic [7:0] m_d;
    logic [7:0] m_rd;
    logic       m_err;
    logic [7:0] m_mem [256];

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_rd     = 8'h00;
            m_err    = 1'b0;
            pending  = 1'b0;
            acc_edge = -100;
            edge_n   = 0;
            done_at  = 0;
        end else begin
            m_idle = !pending && (edge_n != acc_edge);
            edge_n++;
            m_err = 1'b0;
            if (pending) begin
                if (edge_n == done_at) begin
                    if (m_is_wr) m_mem[m_a] = m_d;
                    else         m_rd = m_mem[m_a];
                    pending  = 1'b0;
                    acc_edge = edge_n;
                end
            end else if (m_idle) begin
                if (READ ^ WRITE) begin
                    pending = 1'b1;
                    done_at = edge_n + LAT;
                    m_is_wr = WRITE;
                    m_a     = ADDRESS;
                    m_d     = WRITEDATA;
                end else if (READ && WRITE) begin
                    m_err = 1'b1;
                end
            end
        end
    end

    logic exp_busy;
    always @(negedge CLK) begin
        exp_busy = RESET && (pending || ((edge_n != acc_edge) && (READ ^ WRITE)));
        check("busywait", {31'b0, BUSYWAIT}, {31'b0, exp_busy});
        check("err", {31'b0, ERR}, {31'b0, m_err});
        check("readdata", {24'b0, READDATA}, {24'b0, m_rd});
    end

    // Issue one request, hold it until BUSYWAIT falls, then drop it in the DONE cycle.
    task automatic access(input logic is_wr, input logic [7:0] a, input logic [7:0] d,
                          input bit toggle_addr, output int busy_n, output logic [7:0] rd);
        bit done_seen = 1'b0;
        @(posedge CLK); #1;
        READ = !is_wr; WRITE = is_wr; ADDRESS = a; WRITEDATA = d;
        busy_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (BUSYWAIT) begin
                busy_n++;
                if (toggle_addr && busy_n == 2) begin
                    #1; ADDRESS = 8'h00;
                end
            end else begin
                done_seen = 1'b1;
                break;
            end
        end
        check("access_completes", {31'b0, done_seen}, 32'd1);
        rd = READDATA;
        #1; READ = 1'b0; WRITE = 1'b0;
    endtask

    int         bn;
    int         errs;
    logic [7:0] rd;

    initial begin
        #2;
        check("reset_busywait", {31'b0, BUSYWAIT}, 32'd0);
        check("reset_readdata", {24'b0, READDATA}, 32'd0);
        check("reset_err", {31'b0, ERR}, 32'd0);
        @(posedge CLK); #1; RESET = 1'b1;

        // Reset in the middle of a write aborts it.
        @(posedge CLK); #1;
        WRITE = 1'b1; ADDRESS = 8'h10; WRITEDATA = 8'hAA;
        repeat (3) @(negedge CLK);
        #1; RESET = 1'b0; #1;
        check("reset_mid_busy_busywait", {31'b0, BUSYWAIT}, 32'd0);
        WRITE = 1'b0;
        @(posedge CLK); #1;
        check("reset_mid_busy_readdata", {24'b0, READDATA}, 32'd0);
        RESET = 1'b1;
        access(1'b0, 8'h10, 8'h00, 1'b0, bn, rd);
        check("aborted_write_not_stored", {24'b0, rd}, 32'h00);

        // Store then load with the full latency.
        access(1'b1, 8'h3C, 8'h5A, 1'b0, bn, rd);
        check("write_busy_cycles", bn, 32'd6);
        access(1'b0, 8'h3C, 8'h00, 1'b0, bn, rd);
        check("read_busy_cycles", bn, 32'd6);
        check("read_3c", {24'b0, rd}, 32'h5A);

        // Address changes during BUSY are ignored.
        access(1'b0, 8'h3C, 8'h00, 1'b1, bn, rd);
        check("read_addr_latched", {24'b0, rd}, 32'h5A);

        // Conflicting requests: one ERR pulse per edge, no access.
        @(posedge CLK); #1;
        READ = 1'b1; WRITE = 1'b1; ADDRESS = 8'h77; WRITEDATA = 8'h99;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (ERR) errs++;
            if (i == 2) begin
                #1; READ = 1'b0; WRITE = 1'b0;
            end
        end
        check("err_pulse_count", errs, 32'd2);
        access(1'b0, 8'h77, 8'h00, 1'b0, bn, rd);
        check("err_no_write", {24'b0, rd}, 32'h00);

        // Back-to-back stores at both address extremes.
        access(1'b1, 8'hFF, 8'hFF, 1'b0, bn, rd);
        check("b2b_first_busy", bn, 32'd6);
        access(1'b1, 8'h00, 8'h01, 1'b0, bn, rd);
        check("b2b_second_busy", bn, 32'd6);
        check("write_leaves_readdata", {24'b0, READDATA}, 32'h00);
        access(1'b0, 8'hFF, 8'h00, 1'b0, bn, rd);
        check("readback_ff", {24'b0, rd}, 32'hFF);
        access(1'b0, 8'h00, 8'h00, 1'b0, bn, rd);
        check("readback_00", {24'b0, rd}, 32'h01);

        // LATENCY=1 instance: stall lasts exactly two cycles.
        @(posedge CLK); #1;
        write2 = 1'b1; addr2 = 8'h42; wdata2 = 8'hC3;
        bn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (busy2) bn++; else break;
        end
        #1; write2 = 1'b0;
        check("lat1_write_busy", bn, 32'd2);
        check("lat1_write_keeps_readdata", {24'b0, rdata2}, 32'h00);
        @(posedge CLK); #1;
        read2 = 1'b1;
        bn = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (busy2) bn++; else break;
        end
        check("lat1_read_busy", bn, 32'd2);
        check("lat1_readdata", {24'b0, rdata2}, 32'hC3);
        #1; read2 = 1'b0;

        repeat (3) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
